// File: rtl/nott_pulse_sched.sv
// Round-robin scheduler driving a toggle-coded NOTT cell: pulses nott_a/nott_clk,
// counts nott_q edges in an observation window and returns a one-hot response.
module nott_pulse_sched #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned RESP_CYC  = 4,
  parameter int unsigned GAP_CYC   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_data,
  output logic [1:0] req_ready,
  output logic [1:0] rsp_valid,
  output logic       rsp_data,
  output logic       rsp_err,
  output logic       nott_a,
  output logic       nott_clk,
  input  logic       nott_q,
  output logic       stray_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, DRV_A, SETUP, DRV_CLK, WINDOW, RESP, GAP
  } state_t;

  // Timer reload values; SETUP holds SETUP_CYC-1 cycles after the DRV_A cycle.
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC) - 8'd2;
  localparam logic [7:0] RESP_LD  = 8'(RESP_CYC) - 8'd1;
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYC) - 8'd1;

  state_t     state_q, state_d;
  logic [7:0] tmr_q, tmr_d;
  logic [1:0] ecnt_q, ecnt_d;
  logic       data_q, data_d;
  logic       idx_q, idx_d;
  logic       prio_q, prio_d;
  logic       nott_a_q, nott_a_d;
  logic       nott_clk_q, nott_clk_d;
  logic       stray_q, stray_d;
  logic       qprev_q, qvld_q;
  logic       q_edge;
  logic       gnt_idx;
  logic       rsp_bit;
  logic [1:0] grant;

  // qvld_q suppresses a false edge on the first clock after reset release.
  assign q_edge  = qvld_q & (nott_q ^ qprev_q);
  assign gnt_idx = (&req_valid) ? prio_q : req_valid[1];
  assign rsp_bit = (ecnt_q == 2'd1);

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    ecnt_d     = ecnt_q;
    data_d     = data_q;
    idx_d      = idx_q;
    prio_d     = prio_q;
    nott_a_d   = nott_a_q;
    nott_clk_d = nott_clk_q;
    grant      = '0;
    stray_d    = stray_q | (q_edge & (state_q != WINDOW));

    if ((state_q == WINDOW) && q_edge && (ecnt_q != 2'd3)) begin
      ecnt_d = ecnt_q + 2'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant  = gnt_idx ? 2'b10 : 2'b01;
          idx_d  = gnt_idx;
          data_d = req_data[gnt_idx];
          prio_d = ~gnt_idx;
          if (req_data[gnt_idx]) begin
            nott_a_d = ~nott_a_q;
            state_d  = DRV_A;
          end else begin
            nott_clk_d = ~nott_clk_q;
            state_d    = DRV_CLK;
          end
        end
      end
      DRV_A: begin
        if (SETUP_CYC <= 1) begin
          nott_clk_d = ~nott_clk_q;
          state_d    = DRV_CLK;
        end else begin
          tmr_d   = SETUP_LD;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tmr_q == '0) begin
          nott_clk_d = ~nott_clk_q;
          state_d    = DRV_CLK;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      DRV_CLK: begin
        ecnt_d  = '0;
        tmr_d   = RESP_LD;
        state_d = WINDOW;
      end
      WINDOW: begin
        if (tmr_q == '0) begin
          state_d = RESP;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      RESP: begin
        tmr_d   = GAP_LD;
        state_d = GAP;
      end
      GAP: begin
        if (tmr_q == '0) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      ecnt_q     <= '0;
      data_q     <= 1'b0;
      idx_q      <= 1'b0;
      prio_q     <= 1'b0;
      nott_a_q   <= 1'b0;
      nott_clk_q <= 1'b0;
      stray_q    <= 1'b0;
      qprev_q    <= 1'b0;
      qvld_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      ecnt_q     <= ecnt_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      prio_q     <= prio_d;
      nott_a_q   <= nott_a_d;
      nott_clk_q <= nott_clk_d;
      stray_q    <= stray_d;
      qprev_q    <= nott_q;
      qvld_q     <= 1'b1;
    end
  end

  // req_ready is combinational on req_valid, so it is gated to stay low in reset.
  assign req_ready = rst_n ? grant : '0;
  assign rsp_valid = (state_q == RESP) ? (idx_q ? 2'b10 : 2'b01) : '0;
  assign rsp_data  = (state_q == RESP) & rsp_bit;
  assign rsp_err   = (state_q == RESP) & ((ecnt_q > 2'd1) | (rsp_bit == data_q));
  assign nott_a    = nott_a_q;
  assign nott_clk  = nott_clk_q;
  assign stray_err = stray_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_nott_pulse_sched.sv
// Directed bench for nott_pulse_sched: latency, round-robin, edge counting,
// stray detection and mid-transaction reset.
module tb_nott_pulse_sched;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_data;
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;
  logic       rsp_data;
  logic       rsp_err;
  logic       nott_a;
  logic       nott_clk;
  logic       nott_q;
  logic       stray_err;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  nott_pulse_sched #(
    .SETUP_CYC(2),
    .RESP_CYC (4),
    .GAP_CYC  (GAP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .nott_a   (nott_a),
    .nott_clk (nott_clk),
    .nott_q   (nott_q),
    .stray_err(stray_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Cycle index and event log, sampled on the falling edge.
  int         cyc = 0;
  int         ready_n = 0;
  int         rsp_n = 0;
  int         rsp_cyc = -1;
  logic [1:0] rsp_vec = '0;
  logic       rsp_d = 1'b0;
  logic       rsp_e = 1'b0;
  int         a_n = 0;
  int         a_cyc = -1;
  int         c_n = 0;
  int         c_cyc = -1;
  logic       a_prev = 1'b0;
  logic       c_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (req_ready != 2'b00) ready_n = ready_n + 1;
    if (rsp_valid != 2'b00) begin
      rsp_n   = rsp_n + 1;
      rsp_cyc = cyc;
      rsp_vec = rsp_valid;
      rsp_d   = rsp_data;
      rsp_e   = rsp_err;
    end
    if (nott_a != a_prev) begin
      a_n   = a_n + 1;
      a_cyc = cyc;
    end
    if (nott_clk != c_prev) begin
      c_n   = c_n + 1;
      c_cyc = cyc;
    end
    a_prev = nott_a;
    c_prev = nott_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks = n_checks + 1;
    if (act != exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a request and wait (bounded) for its acceptance cycle T.
  task automatic accept(input logic [1:0] v, input logic [1:0] d,
                        output int t, output logic [1:0] g);
    int i;
    req_valid = v;
    req_data  = d;
    t = -1;
    g = '0;
    i = 0;
    while (t < 0 && i < 80) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        t = cyc;
        g = req_ready;
      end
      @(posedge clk);
      #1;
      i = i + 1;
    end
    req_valid = req_valid & ~g;
    check_eq("accepted", int'(t >= 0), 1);
  endtask

  int         t, t2, a0, r0, rd0;
  logic [1:0] g;
  logic [1:0] exp_g [0:3];

  initial begin
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    rst_n = 1'b0; req_valid = 2'b11; req_data = 2'b00; nott_q = 1'b1;

    // Reset state, with requests pending
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", int'(req_ready), 0);
    check_eq("rst_outs", int'({rsp_valid, rsp_data, rsp_err, nott_a, nott_clk, stray_err, busy}), 0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    run_to(cyc + 4);
    check_eq("rel_no_stray", int'(stray_err), 0);
    check_eq("rel_idle", int'(busy), 0);

    // Requester 0, data=0, one window edge at T+3
    a0 = a_n; r0 = rsp_n;
    accept(2'b01, 2'b00, t, g);
    check_eq("t2_grant", int'(g), 1);
    run_to(t + 3);
    nott_q = ~nott_q;
    run_to(t + 12);
    check_eq("t2_clk_cyc", c_cyc - t, 1);
    check_eq("t2_no_a", a_n - a0, 0);
    check_eq("t2_rsp_n", rsp_n - r0, 1);
    check_eq("t2_rsp_cyc", rsp_cyc - t, 6);
    check_eq("t2_rsp_vec", int'(rsp_vec), 1);
    check_eq("t2_rsp_data", int'(rsp_d), 1);
    check_eq("t2_rsp_err", int'(rsp_e), 0);
    check_eq("t2_stray", int'(stray_err), 0);

    // Requester 1, data=1, no edge
    a0 = a_n; r0 = rsp_n;
    accept(2'b10, 2'b10, t, g);
    check_eq("t3_grant", int'(g), 2);
    run_to(t + 12);
    check_eq("t3_a_cnt", a_n - a0, 1);
    check_eq("t3_a_cyc", a_cyc - t, 1);
    check_eq("t3_clk_cyc", c_cyc - t, 3);
    check_eq("t3_rsp_cyc", rsp_cyc - t, 8);
    check_eq("t3_rsp_vec", int'(rsp_vec), 2);
    check_eq("t3_rsp_data", int'(rsp_d), 0);
    check_eq("t3_rsp_err", int'(rsp_e), 0);

    // Both held valid: round-robin alternation and gap after each response
    r0 = rsp_n;
    for (int k = 0; k < 4; k++) begin
      accept(2'b11, 2'b00, t, g);
      check_eq($sformatf("rr_grant%0d", k), int'(g), int'(exp_g[k]));
      if (k > 0) begin
        check_eq($sformatf("rr_gap%0d", k), int'((t - rsp_cyc) >= GAP), 1);
        check_eq($sformatf("rr_prev_vec%0d", k), int'(rsp_vec), int'(exp_g[k-1]));
      end
    end
    req_valid = 2'b00;
    run_to(t + 12);
    check_eq("rr_rsp_n", rsp_n - r0, 4);
    check_eq("rr_last_vec", int'(rsp_vec), 2);
    check_eq("rr_last_err", int'(rsp_e), 1);

    // Two window edges, then a stray edge during GAP
    accept(2'b01, 2'b00, t, g);
    run_to(t + 3);
    nott_q = ~nott_q;
    run_to(t + 4);
    nott_q = ~nott_q;
    run_to(t + 6);
    check_eq("t5_pre_stray", int'(stray_err), 0);
    run_to(t + 7);
    nott_q = ~nott_q;
    run_to(t + 8);
    check_eq("t5_stray_set", int'(stray_err), 1);
    run_to(t + 20);
    check_eq("t5_stray_hold", int'(stray_err), 1);
    check_eq("t5_rsp_data", int'(rsp_d), 0);
    check_eq("t5_rsp_err", int'(rsp_e), 1);

    // Reset at T+4 of a data=1 transaction from requester 0
    r0 = rsp_n;
    accept(2'b01, 2'b01, t, g);
    run_to(t + 4);
    rst_n = 1'b0;
    nott_q = 1'b1;
    #1;
    check_eq("t6_rst_outs", int'({req_ready, rsp_valid, rsp_data, rsp_err, nott_a, nott_clk, stray_err, busy}), 0);
    run_to(t + 7);
    check_eq("t6_rst_hold", int'({nott_a, nott_clk, stray_err, busy}), 0);
    rst_n = 1'b1;
    run_to(t + 12);
    check_eq("t6_no_rsp", rsp_n - r0, 0);
    check_eq("t6_no_stray", int'(stray_err), 0);

    // After reset requester 0 wins; edge on the nott_clk toggle cycle is stray;
    // a request withdrawn while busy is ignored
    accept(2'b11, 2'b00, t2, g);
    req_valid = 2'b00;
    check_eq("t6_first_grant", int'(g), 1);
    rd0 = ready_n;
    nott_q = ~nott_q;
    run_to(t2 + 2);
    check_eq("t7_stray", int'(stray_err), 1);
    req_valid = 2'b10;
    run_to(t2 + 3);
    req_valid = 2'b00;
    run_to(t2 + 20);
    check_eq("t7_rsp_cyc", rsp_cyc - t2, 6);
    check_eq("t7_rsp_data", int'(rsp_d), 0);
    check_eq("t7_rsp_err", int'(rsp_e), 1);
    check_eq("t7_no_grant", ready_n - rd0, 0);
    check_eq("t7_idle", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nott_pulse_sched.md
NOTT_PULSE_SCHED -- requirements
Module: nott_pulse_sched

Interface
REQ-001 Parameter SETUP_CYC, default 2, number of cycles from the nott_a toggle to the nott_clk toggle (minimum 1).
REQ-002 Parameter RESP_CYC, default 4, length in cycles of the nott_q observation window (minimum 1).
REQ-003 Parameter GAP_CYC, default 2, number of cycles from rsp_valid to the earliest next req_ready (minimum 1).
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  2  per-requester request; held high until accepted.
REQ-007 req_data  in  2  per-requester data bit to be inverted by the NOTT cell.
REQ-008 req_ready  out  2  one-hot acceptance pulse, one cycle.
REQ-009 rsp_valid  out  2  one-hot response pulse to the granted requester, one cycle.
REQ-010 rsp_data  out  1  observed NOTT result, valid with rsp_valid.
REQ-011 rsp_err  out  1  mismatch flag, valid with rsp_valid.
REQ-012 nott_a  out  1  toggle-coded data line to the NOTT cell; each level change is one pulse.
REQ-013 nott_clk  out  1  toggle-coded clock line to the NOTT cell.
REQ-014 nott_q  in  1  toggle-coded NOTT output, synchronous to clk.
REQ-015 stray_err  out  1  sticky flag for an nott_q edge outside any window.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, DRV_A, SETUP, DRV_CLK, WINDOW, RESP and GAP.
REQ-018 IDLE: if any req_valid is high, the block SHALL assert req_ready for exactly one requester in that cycle T and latch its req_data and index.
REQ-019 Arbitration SHALL be round-robin: when both requests are valid, grant goes to the requester not granted last; after reset, requester 0 has priority.
REQ-020 req_ready SHALL be asserted only in IDLE.
REQ-021 When data=1, nott_a SHALL toggle in cycle T+1 and nott_clk SHALL toggle in cycle T+1+SETUP_CYC.
REQ-022 When data=0, nott_a SHALL NOT toggle and nott_clk SHALL toggle in cycle T+1.
REQ-023 Edge detection: an nott_q edge in a cycle SHALL be defined as nott_q differing from its value registered in the previous cycle.
REQ-024 The window SHALL span the RESP_CYC cycles following the nott_clk toggle cycle, with edges counted in a 2-bit saturating counter.
REQ-025 rsp_valid for the latched index SHALL pulse in the cycle after the window ends, with rsp_data=1 if exactly one edge was counted, otherwise 0.
REQ-026 rsp_err SHALL be 1 if edge count >1 or rsp_data != ~data, otherwise 0.
REQ-027 GAP SHALL hold for GAP_CYC cycles after the rsp_valid cycle, after which the FSM returns to IDLE.
REQ-028 Latency with defaults: data=1 gives rsp_valid at T+8 and next req_ready no earlier than T+10; data=0 gives rsp_valid at T+6 and next req_ready no earlier than T+8.
REQ-029 An nott_q edge in any state other than WINDOW SHALL set stray_err, which SHALL clear only on reset.
REQ-030 An nott_q edge in the same cycle as the nott_clk toggle SHALL count as stray, not as a window edge.
REQ-031 A req_valid deasserted before acceptance SHALL be ignored, with no state change.

Reset
REQ-032 While rst_n is low, all outputs SHALL be 0, the FSM SHALL be in IDLE and round-robin priority SHALL be on requester 0.
REQ-033 Reset mid-operation SHALL abort the transaction without emitting rsp_valid, and stray_err SHALL clear.
REQ-034 After rst_n rises, the registered nott_q value SHALL be loaded from nott_q on the first clock edge without flagging an edge.

Verification
REQ-035 Requester 0 sends data=0 and the model toggles nott_q once at T+3 -> nott_clk toggles at T+1, rsp_valid=01 at T+6, rsp_data=1, rsp_err=0.
REQ-036 Requester 1 sends data=1 with no nott_q edge -> nott_a toggles at T+1, nott_clk toggles at T+3, rsp_valid=10 at T+8, rsp_data=0, rsp_err=0.
REQ-037 Both requesters are held valid for 4 transactions -> grants are 0,1,0,1 and each req_ready follows the previous rsp_valid by at least GAP_CYC cycles.
REQ-038 data=0 with two nott_q edges in the window -> rsp_data=0, rsp_err=1; a later nott_q edge during GAP -> stray_err=1, held until reset.
REQ-039 rst_n is pulled low at T+4 of a data=1 transaction -> no rsp_valid, all outputs 0, and after release requester 0 is granted first.
